// File: rtl/calc_control.sv
// Keypad sequencer for a four-function calculator. Decodes one key per
// key_valid strobe into single-cycle write commands for the operand/operator
// storage, tracks which operand is being entered, limits operand length to
// MAX_DIGITS, and expands a digit typed over a displayed result into a
// two-cycle "clear, then write digit" sequence.
module calc_control #(
  parameter int MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic [3:0] num,
  output logic [1:0] operator,
  output logic [1:0] save_enable,
  output logic       clear_enable,
  output logic       equ_enable,
  output logic       op_enable,
  output logic       busy,
  output logic       overflow,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_OP1 = 2'b00,
    S_OPR = 2'b01,
    S_OP2 = 2'b10,
    S_RES = 2'b11
  } state_t;

  localparam logic [1:0] SAVE_NONE = 2'b00;
  localparam logic [1:0] SAVE_OP1  = 2'b01;  // operand 1 or result
  localparam logic [1:0] SAVE_OPR  = 2'b10;  // operator write or full clear
  localparam logic [1:0] SAVE_OP2  = 2'b11;

  // Counters only need to reach MAX_DIGITS (at most 4).
  localparam int          CW      = 3;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt1_q, cnt1_d;
  logic [CW-1:0]   cnt2_q, cnt2_d;
  logic [3:0]      held_q, held_d;
  logic            busy_q, busy_d;
  logic [3:0]      num_q, num_d;
  logic [1:0]      opr_q, opr_d;
  logic [1:0]      save_q, save_d;
  logic            clear_q, clear_d;
  logic            equ_q, equ_d;
  logic            op_q, op_d;
  logic            ovf_q, ovf_d;

  logic is_digit, is_opr, is_equ, is_clr;

  assign is_digit = (key_code <= 4'd9);
  assign is_opr   = (key_code >= 4'hA) && (key_code <= 4'hD);
  assign is_equ   = (key_code == 4'hE);
  assign is_clr   = (key_code == 4'hF);

  // State, counters, held digit and all command outputs are registered here.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    if (!rst_n) begin
      // NOTE: the held digit is reset too, so an aborted two-cycle sequence
      // cannot leak a stale digit into a later write.
      state_q <= S_OP1;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      held_q  <= '0;
      busy_q  <= 1'b0;
      num_q   <= '0;
      opr_q   <= '0;
      save_q  <= SAVE_NONE;
      clear_q <= 1'b0;
      equ_q   <= 1'b0;
      op_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      held_q  <= held_d;
      busy_q  <= busy_d;
      num_q   <= num_d;
      opr_q   <= opr_d;
      save_q  <= save_d;
      clear_q <= clear_d;
      equ_q   <= equ_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
    end
  end

  // Key decode: next state, counter updates and the next command pulse.
  always_comb begin
    // NOTE: every target gets a default first, so no path infers a latch and
    // the pulse outputs fall back to zero on any cycle without a command.
    state_d = state_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    held_d  = held_q;
    busy_d  = 1'b0;
    num_d   = num_q;
    opr_d   = opr_q;
    save_d  = SAVE_NONE;
    clear_d = 1'b0;
    equ_d   = 1'b0;
    op_d    = 1'b0;
    ovf_d   = 1'b0;

    if (busy_q) begin
      // Second half of "digit over result": write the held digit. Any key
      // arriving this cycle, clear included, is dropped.
      save_d  = SAVE_OP1;
      num_d   = held_q;
      cnt1_d  = CW'(1);
      state_d = S_OP1;
    end else if (key_valid) begin
      if (is_clr) begin
        save_d  = SAVE_OPR;
        clear_d = 1'b1;
        state_d = S_OP1;
        cnt1_d  = '0;
        cnt2_d  = '0;
      end else begin
        unique case (state_q)
          S_OP1: begin
            if (is_digit) begin
              if (cnt1_q < CNT_MAX) begin
                save_d = SAVE_OP1;
                num_d  = key_code;
                cnt1_d = cnt1_q + CW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end else if (is_opr) begin
              save_d  = SAVE_OPR;
              op_d    = 1'b1;
              opr_d   = 2'(key_code - 4'hA);
              cnt2_d  = '0;
              state_d = S_OPR;
            end
          end
          S_OPR: begin
            if (is_digit) begin
              save_d  = SAVE_OP2;
              num_d   = key_code;
              cnt2_d  = CW'(1);
              state_d = S_OP2;
            end else if (is_opr) begin
              save_d = SAVE_OPR;
              op_d   = 1'b1;
              opr_d  = 2'(key_code - 4'hA);
            end
          end
          S_OP2: begin
            if (is_digit) begin
              if (cnt2_q < CNT_MAX) begin
                save_d = SAVE_OP2;
                num_d  = key_code;
                cnt2_d = cnt2_q + CW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end else if (is_equ) begin
              save_d  = SAVE_OP1;
              equ_d   = 1'b1;
              state_d = S_RES;
            end
          end
          S_RES: begin
            if (is_digit) begin
              // First half: full clear now, digit write on the next cycle.
              save_d  = SAVE_OPR;
              clear_d = 1'b1;
              state_d = S_OP1;
              cnt1_d  = '0;
              cnt2_d  = '0;
              held_d  = key_code;
              busy_d  = 1'b1;
            end
          end
          default: state_d = S_OP1;
        endcase
      end
    end
  end

  assign num          = num_q;
  assign operator     = opr_q;
  assign save_enable  = save_q;
  assign clear_enable = clear_q;
  assign equ_enable   = equ_q;
  assign op_enable    = op_q;
  assign busy         = busy_q;
  assign overflow     = ovf_q;
  assign state        = state_q;

endmodule

// File: tb/tb_calc_control.sv
// Self-checking bench for calc_control: directed key sequences push the
// hand-derived command they should produce into a scoreboard queue; a monitor
// pops and compares every time the DUT emits a command or overflow pulse.
module tb_calc_control;

  localparam logic [1:0] S_OP1 = 2'b00;
  localparam logic [1:0] S_OPR = 2'b01;
  localparam logic [1:0] S_OP2 = 2'b10;
  localparam logic [1:0] S_RES = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] num;
  logic [1:0] operator;
  logic [1:0] save_enable;
  logic       clear_enable, equ_enable, op_enable, busy, overflow;
  logic [1:0] state;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [1:0] se;
    logic [3:0] num;
    logic [1:0] opr;
    logic       clr, equ, op, bsy, ovf;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  calc_control #(.MAX_DIGITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .num          (num),
    .operator     (operator),
    .save_enable  (save_enable),
    .clear_enable (clear_enable),
    .equ_enable   (equ_enable),
    .op_enable    (op_enable),
    .busy         (busy),
    .overflow     (overflow),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] se, input logic [3:0] n, input logic [1:0] o,
                      input logic clr, input logic equ, input logic op,
                      input logic bsy, input logic ovf, input logic [1:0] st);
    exp_t e;
    e.se = se; e.num = n; e.opr = o; e.clr = clr; e.equ = equ;
    e.op = op; e.bsy = bsy; e.ovf = ovf; e.st = st;
    sb.push_back(e);
  endtask

  task automatic exp_d1(input logic [3:0] n);
    push(2'b01, n, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_OP1);
  endtask
  task automatic exp_d2(input logic [3:0] n);
    push(2'b11, n, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_OP2);
  endtask
  task automatic exp_op(input logic [1:0] o);
    push(2'b10, 4'h0, o, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_OPR);
  endtask
  task automatic exp_clr(input logic bsy);
    push(2'b10, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, bsy, 1'b0, S_OP1);
  endtask
  task automatic exp_equ();
    push(2'b01, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_RES);
  endtask
  task automatic exp_ovf(input logic [1:0] st);
    push(2'b00, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, st);
  endtask

  // One key per cycle; key_code is left at 0xF with key_valid low afterwards,
  // which must be ignored.
  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  // Monitor: every emitted command or overflow pulse must match the queue head.
  always @(negedge clk) begin
    if (save_enable != 2'b00 || overflow || clear_enable || equ_enable || op_enable) begin
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL unexpected_cmd: got se=%b clr=%b equ=%b op=%b ovf=%b num=%h, expected no command",
                 save_enable, clear_enable, equ_enable, op_enable, overflow, num);
      end else begin
        exp_t e;
        logic bad;
        e = sb.pop_front();
        bad = (save_enable !== e.se) || (clear_enable !== e.clr) || (equ_enable !== e.equ) ||
              (op_enable !== e.op) || (busy !== e.bsy) || (overflow !== e.ovf) ||
              (state !== e.st);
        if ((e.se == 2'b01 || e.se == 2'b11) && !e.equ && (num !== e.num)) bad = 1'b1;
        if (e.op && (operator !== e.opr)) bad = 1'b1;
        if (bad) begin
          failed++;
          $display("FAIL cmd: got se=%b num=%h opr=%b clr=%b equ=%b op=%b busy=%b ovf=%b st=%b, expected se=%b num=%h opr=%b clr=%b equ=%b op=%b busy=%b ovf=%b st=%b",
                   save_enable, num, operator, clear_enable, equ_enable, op_enable, busy, overflow, state,
                   e.se, e.num, e.opr, e.clr, e.equ, e.op, e.bsy, e.ovf, e.st);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_save"},  32'(save_enable), 32'd0);
    check({tag, "_flags"}, 32'({clear_enable, equ_enable, op_enable, busy, overflow}), 32'd0);
    check({tag, "_num"},   32'(num), 32'd0);
    check({tag, "_opr"},   32'(operator), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(S_OP1));
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b1;  // keys during reset must be ignored
    key_code  = 4'h5;
    repeat (3) @(posedge clk);
    #1;
    key_valid = 1'b0;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1,2,+,3,= with stray equals first and stray keys in S_RES.
    press(4'hE);
    exp_d1(4'h1); press(4'h1);
    exp_d1(4'h2); press(4'h2);
    exp_op(2'b00); press(4'hA);
    exp_d2(4'h3); press(4'h3);
    exp_equ();    press(4'hE);
    press(4'hB);
    press(4'hE);
    check("res_state", 32'(state), 32'(S_RES));

    // Digit over result: clear with busy, then the held digit.
    exp_clr(1'b1); exp_d1(4'h7); press(4'h7);
    @(posedge clk); #1;
    check("after_busy", 32'({busy, state}), 32'({1'b0, S_OP1}));

    // Operand 1 digit limit and saturation.
    exp_clr(1'b0); press(4'hF);
    exp_d1(4'h1); press(4'h1);
    exp_d1(4'h2); press(4'h2);
    exp_d1(4'h3); press(4'h3);
    exp_d1(4'h4); press(4'h4);
    exp_ovf(S_OP1); press(4'h5);
    exp_ovf(S_OP1); press(4'h6);
    press(4'hE);

    // Operator replacement, operand 2 limit, ignored operator in S_OP2.
    exp_clr(1'b0); press(4'hF);
    exp_d1(4'h5); press(4'h5);
    exp_op(2'b00); press(4'hA);
    exp_op(2'b01); press(4'hB);
    check("opr_replaced", 32'({operator, state}), 32'({2'b01, S_OPR}));
    exp_d2(4'h2); press(4'h2);
    press(4'hC);
    exp_d2(4'h3); press(4'h3);
    exp_d2(4'h4); press(4'h4);
    exp_d2(4'h5); press(4'h5);
    exp_ovf(S_OP2); press(4'h6);
    exp_equ(); press(4'hE);

    // Clear pressed while busy is dropped; held 9 still written.
    exp_clr(1'b1); exp_d1(4'h9); press(4'h9);
    press(4'hF);
    exp_op(2'b11); press(4'hD);
    exp_d2(4'h1); press(4'h1);
    exp_equ(); press(4'hE);

    // Reset on the busy cycle aborts the digit write.
    exp_clr(1'b1); press(4'h7);
    rst_n     = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    check_idle_outputs("abort");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_d1(4'h8); press(4'h8);

    begin
      int w = 0;
      while (sb.size() != 0 && w < 20) begin
        @(posedge clk);
        w++;
      end
    end
    @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/calc_control.md
CALC_CONTROL -- requirements
Module: calc_control

Interface
REQ-001 Parameter: MAX_DIGITS, default 4, maximum digits accepted per operand (1..4).
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 Port: key_code  input  4  key code: 0x0-0x9 digit, 0xA add, 0xB sub, 0xC mul, 0xD div, 0xE equals, 0xF clear.
REQ-005 Port: key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-006 Port: num  output  4  digit nibble to operand memory; valid while save_enable is 2'b01 or 2'b11 with equ_enable and clear_enable low.
REQ-007 Port: operator  output  2  operator code (add 00, sub 01, mul 10, div 11); valid while save_enable=2'b10.
REQ-008 Port: save_enable  output  2  one-cycle command: 00 none, 01 operand 1 or result, 10 operator, 11 operand 2.
REQ-009 Port: clear_enable  output  1  high with save_enable=2'b10 for a full clear.
REQ-010 Port: equ_enable  output  1  high with save_enable=2'b01 to load the result into operand 1.
REQ-011 Port: op_enable  output  1  high with save_enable=2'b10 for an operator write.
REQ-012 Port: busy  output  1  high while a two-cycle command sequence is in progress.
REQ-013 Port: overflow  output  1  one-cycle pulse when a digit is dropped because of the digit limit.
REQ-014 Port: state  output  2  current FSM state: S_OP1 00, S_OPR 01, S_OP2 10, S_RES 11.

Function
REQ-015 All outputs shall be registered, and the command shall appear on the cycle after key_valid is sampled (latency 1).
REQ-016 save_enable, equ_enable, clear_enable, op_enable and overflow shall be single-cycle pulses and shall return to 0 on the following cycle.
REQ-017 At most one command shall be issued per cycle, and save_enable shall be 00 whenever no command is issued.
REQ-018 Clear key in any state: issue save_enable=10 with clear_enable=1, go to S_OP1, and zero both digit counters.
REQ-019 S_OP1 digit: if cnt1<MAX_DIGITS, issue 01 with num=key_code and increment cnt1; otherwise issue no command and pulse overflow.
REQ-020 S_OP1 operator key: issue 10 with op_enable=1 and operator=key_code-0xA, zero cnt2, and go to S_OPR.
REQ-021 S_OP1 equals key: ignore it, with no command and no state change.
REQ-022 S_OPR digit: issue 11 with num, set cnt2=1, and go to S_OP2.
REQ-023 S_OPR operator key: reissue 10 with the new operator, which replaces the previous one, and stay in S_OPR.
REQ-024 S_OPR equals key: ignore it.
REQ-025 S_OP2 digit: if cnt2<MAX_DIGITS, issue 11 and increment cnt2; otherwise pulse overflow and issue no command.
REQ-026 S_OP2 operator key: ignore it; operator chaining is not supported.
REQ-027 S_OP2 equals key: issue 01 with equ_enable=1 and go to S_RES.
REQ-028 S_RES digit, first cycle: issue a full clear as in REQ-018, hold the digit internally, and set busy=1.
REQ-029 S_RES digit, second cycle: issue 01 with the held digit, set cnt1=1, go to S_OP1, and set busy=0.
REQ-030 S_RES operator and equals keys: ignore them.
REQ-031 key_valid while busy=1: drop the key, with no command and no state change; the clear key is dropped too.
REQ-032 key_code values not defined in REQ-004 cannot occur; all 16 codes are defined.
REQ-033 The digit counters shall saturate at MAX_DIGITS and shall never wrap.
REQ-034 The key_code input shall be ignored whenever key_valid=0.

Reset
REQ-035 With rst_n=0 at a clock edge, the block shall enter S_OP1, zero cnt1, cnt2, num, operator and save_enable, drive clear_enable, equ_enable, op_enable, busy and overflow to 0, and discard any held digit.
REQ-036 Reset asserted mid-sequence (busy=1) shall abort the sequence, so the second-cycle command shall not be issued.
REQ-037 Keys presented while rst_n=0 shall be ignored.

Verification
REQ-038 Keys 1,2,+,3,= -> four cycles carry save_enable 01/01/10/11, then 01 with equ_enable=1; num values 1,2,_,3; operator 00; final state S_RES.
REQ-039 Keys 1,2,3,4,5 with MAX_DIGITS=4 -> four 01 commands, then the fifth key produces an overflow pulse with save_enable=00.
REQ-040 In S_RES, key 7 -> cycle N+1 carries save_enable=10 with clear_enable=1 and busy=1; cycle N+2 carries 01 with num=7; busy drops; state S_OP1.
REQ-041 Keys 5,+,-,2 -> operator writes 00 then 01, the state stays S_OPR between them, and the final operator is 01.
REQ-042 Key 9 followed by key 0xF on the next cycle in S_RES -> the 0xF key is dropped while busy=1, and the 01 command with num=9 is still issued.
REQ-043 rst_n low on the busy cycle of REQ-040 -> no digit write follows, and all outputs are 0 with state S_OP1.
